// File: rtl/grf_wr_arbiter.sv
// Round-robin arbiter sharing the single GRF write port among N_REQ writeback
// sources; one grant per cycle, registered write controls one cycle later.
module grf_wr_arbiter #(
  parameter int N_REQ = 3,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ*DW-1:0] req_pc,
  output logic [N_REQ-1:0]    req_ready,
  output logic                grf_we,
  output logic [AW-1:0]       grf_a3,
  output logic [DW-1:0]       grf_wd,
  output logic [DW-1:0]       grf_pc,
  output logic                busy
);
  localparam int PW = $clog2(N_REQ);

  logic [N_REQ-1:0][AW-1:0] addr_a;
  logic [N_REQ-1:0][DW-1:0] data_a, pc_a;
  logic [PW-1:0]            last, gnt_idx, j;
  logic [PW:0]              s;
  logic [N_REQ-1:0]         gnt;
  logic                     found;

  assign addr_a = req_addr;
  assign data_a = req_data;
  assign pc_a   = req_pc;

  // Scan last+1 .. last+N_REQ (mod N_REQ); first valid wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = last;
    found   = 1'b0;
    s       = '0;
    j       = '0;
    if (!hold && !reset) begin
      for (int k = 0; k < N_REQ; k++) begin
        s = {1'b0, last} + (PW+1)'(k + 1);
        if (s >= (PW+1)'(N_REQ)) s = s - (PW+1)'(N_REQ);
        j = s[PW-1:0];
        if (!found && req_valid[j]) begin
          found   = 1'b1;
          gnt[j]  = 1'b1;
          gnt_idx = j;
        end
      end
    end
  end

  assign req_ready = gnt;
  assign busy      = (|req_valid) | grf_we;

  // gnt is only ever set on a valid requester, so |gnt marks a transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last   <= PW'(N_REQ - 1);
      grf_we <= 1'b0;
      grf_a3 <= '0;
      grf_wd <= '0;
      grf_pc <= '0;
    end else begin
      grf_we <= 1'b0;
      if (|gnt) begin
        last   <= gnt_idx;
        grf_we <= |addr_a[gnt_idx];
        grf_a3 <= addr_a[gnt_idx];
        grf_wd <= data_a[gnt_idx];
        grf_pc <= pc_a[gnt_idx];
      end
    end
  end
endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Directed bench for grf_wr_arbiter: reset, single write, round-robin order,
// $0 writes, hold, and asynchronous reset mid-stream.
module tb_grf_wr_arbiter;
  localparam int N = 3, AW = 5, DW = 32;

  logic                   clk, reset, hold;
  logic [N-1:0]           req_valid;
  logic [N-1:0][AW-1:0]   addr_v;
  logic [N-1:0][DW-1:0]   data_v, pc_v;
  logic [N-1:0]           req_ready;
  logic                   grf_we, busy;
  logic [AW-1:0]          grf_a3;
  logic [DW-1:0]          grf_wd, grf_pc;

  int n_assert = 0;
  int n_fail   = 0;

  grf_wr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_addr(addr_v), .req_data(data_v), .req_pc(pc_v),
    .req_ready(req_ready), .grf_we(grf_we), .grf_a3(grf_a3),
    .grf_wd(grf_wd), .grf_pc(grf_pc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_g [6];
    exp_g = '{1, 2, 0, 1, 2, 0};
    reset = 1'b1; hold = 1'b0; req_valid = '0;
    addr_v = '0; data_v = '0; pc_v = '0;

    // Reset: outputs clear, ready gated even with a valid request
    #3;
    req_valid = 3'b001;
    #1;
    chk("rst_we",    32'(grf_we), 32'd0);
    chk("rst_a3",    32'(grf_a3), 32'd0);
    chk("rst_wd",    grf_wd, 32'd0);
    chk("rst_pc",    grf_pc, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy",  32'(busy), 32'd1);
    req_valid = '0;
    tick();
    reset = 1'b0;
    tick();
    chk("idle_we",   32'(grf_we), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rdy",  32'(req_ready), 32'd0);

    // Single request from port 0
    addr_v[0] = 5'd5; data_v[0] = 32'h1234_5678; pc_v[0] = 32'h0000_3000;
    req_valid = 3'b001;
    #1;
    chk("single_rdy", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    chk("single_we", 32'(grf_we), 32'd1);
    chk("single_a3", 32'(grf_a3), 32'd5);
    chk("single_wd", grf_wd, 32'h1234_5678);
    chk("single_pc", grf_pc, 32'h0000_3000);
    chk("single_busy", 32'(busy), 32'd1);
    tick();
    chk("single_we_drop", 32'(grf_we), 32'd0);
    chk("single_a3_hold", 32'(grf_a3), 32'd5);
    chk("single_busy_drop", 32'(busy), 32'd0);

    // All valid; pointer sits at 0, so the rotation starts at port 1
    for (int i = 0; i < N; i++) begin
      addr_v[i] = AW'(i + 1);
      data_v[i] = 32'hA000_0000 + 32'(i);
      pc_v[i]   = 32'h0000_4000 + 32'(4 * i);
    end
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr_rdy", 32'(req_ready), 32'(1) << exp_g[c]);
      tick();
      chk("rr_we", 32'(grf_we), 32'd1);
      chk("rr_a3", 32'(grf_a3), 32'(exp_g[c] + 1));
      chk("rr_wd", grf_wd, 32'hA000_0000 + 32'(exp_g[c]));
    end
    req_valid = '0;

    // $0 write from port 1: consumed, no write enable, pointer advances
    addr_v[1] = 5'd0; data_v[1] = 32'hFFFF_FFFF;
    req_valid = 3'b010;
    #1;
    chk("zero_rdy", 32'(req_ready), 32'b010);
    tick();
    req_valid = '0;
    chk("zero_we", 32'(grf_we), 32'd0);
    chk("zero_wd", grf_wd, 32'hFFFF_FFFF);
    req_valid = 3'b101;
    #1;
    chk("zero_next_rdy", 32'(req_ready), 32'b100);
    tick();
    req_valid = '0;
    chk("zero_next_we", 32'(grf_we), 32'd1);
    chk("zero_next_a3", 32'(grf_a3), 32'd3);

    // hold for two cycles, then port 0 wins (pointer still at 2)
    addr_v[0] = 5'd4; data_v[0] = 32'hCAFE_0004;
    req_valid = 3'b011;
    hold = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("hold_rdy", 32'(req_ready), 32'd0);
      tick();
      chk("hold_we", 32'(grf_we), 32'd0);
    end
    hold = 1'b0;
    #1;
    chk("hold_rel_rdy", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    chk("hold_rel_we", 32'(grf_we), 32'd1);
    chk("hold_rel_a3", 32'(grf_a3), 32'd4);
    chk("hold_rel_wd", grf_wd, 32'hCAFE_0004);

    // Async reset right after a transfer discards the pending write
    req_valid = 3'b100;
    #1;
    chk("ar_rdy", 32'(req_ready), 32'b100);
    tick();
    chk("ar_we_pre", 32'(grf_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_we", 32'(grf_we), 32'd0);
    chk("ar_a3", 32'(grf_a3), 32'd0);
    chk("ar_rdy_rst", 32'(req_ready), 32'd0);
    #1 reset = 1'b0;
    addr_v[0] = 5'd1;
    req_valid = 3'b111;
    #1;
    chk("ar_restart_rdy", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    chk("ar_restart_we", 32'(grf_we), 32'd1);
    chk("ar_restart_a3", 32'(grf_a3), 32'd1);
    tick();
    chk("end_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
